lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lock_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// Keypad lock controller driving an external digit shift register.
// Optional feature: define LOCK_ALARM_EN for wrong-code counting and the ALARM state.
module lock_ctrl #(
   parameter int CODE_LEN  = 4,
   parameter int TRIES     = 3,
   parameter int OPEN_CYC  = 5000,
   parameter int ALARM_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  key,
   input  logic        key_strobe,
   output logic [3:0]  sr_en,
   output logic [4:0]  sr_in,
   output logic        sr_rst,
   input  logic [31:0] sr_out,
   output logic        unlocked,
   output logic        alarm,
   output logic [1:0]  state,
   output logic [3:0]  digit_cnt
);

   typedef enum logic [1:0] {
      SETUP  = 2'd0,
      LOCKED = 2'd1,
      OPEN   = 2'd2,
      ALARM  = 2'd3
   } st_t;

   localparam int          CW   = 4 * CODE_LEN;
   localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - CW);
   localparam int          TW   = $clog2(OPEN_CYC + ALARM_CYC + 1);

   st_t           st, st_n;
   logic [3:0]    cnt, cnt_n;
   logic [TW-1:0] tmr, tmr_n;
   logic          clr, clr_n;
   logic [31:0]   code;
   logic          code_ld;
   logic          kv, k_dig, k_ent, k_clr, accept, match;

`ifdef LOCK_ALARM_EN
   localparam int FW = $clog2(TRIES + 1);
   logic [FW-1:0] fail, fail_n;
`endif

   assign state     = st;
   assign digit_cnt = cnt;
   // clr marks the one-cycle shift-register flush after ENTER/CLEAR or reset
   assign sr_rst    = rst | clr;

   always_comb begin
      kv      = key_strobe && !clr && !rst;
      k_dig   = kv && (key <= 5'd9);
      k_ent   = kv && (key == 5'd10);
      k_clr   = kv && (key == 5'd11);
      match   = (cnt == 4'(CODE_LEN)) && ((sr_out & MASK) == code);
      st_n    = st;
      cnt_n   = clr ? 4'd0 : cnt;
      tmr_n   = '0;
      clr_n   = 1'b0;
      code_ld = 1'b0;
      accept  = 1'b0;
`ifdef LOCK_ALARM_EN
      fail_n  = fail;
`endif
      case (st)
         SETUP, LOCKED: begin
            if (k_dig) begin
               if (cnt < 4'(CODE_LEN)) begin
                  accept = 1'b1;
                  cnt_n  = cnt + 4'd1;
               end
            end else if (k_clr) begin
               clr_n = 1'b1;
               cnt_n = 4'd0;
            end else if (k_ent) begin
               clr_n = 1'b1;
               cnt_n = 4'd0;
               if (st == SETUP) begin
                  if (cnt == 4'(CODE_LEN)) begin
                     code_ld = 1'b1;
                     st_n    = LOCKED;
                  end
               end else if (match) begin
                  st_n = OPEN;
`ifdef LOCK_ALARM_EN
                  fail_n = '0;
`endif
               end else begin
`ifdef LOCK_ALARM_EN
                  fail_n = fail + 1'b1;
                  if (fail == FW'(TRIES - 1))
                     st_n = ALARM;
`endif
               end
            end
         end
         OPEN: begin
            if (k_ent) begin
               st_n  = LOCKED;
               clr_n = 1'b1;
            end else if (k_clr) begin
               st_n  = SETUP;
               clr_n = 1'b1;
            end else if (tmr == TW'(OPEN_CYC - 1)) begin
               st_n = LOCKED;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         default: begin
`ifdef LOCK_ALARM_EN
            // every key is dropped while the alarm runs
            if (tmr == TW'(ALARM_CYC - 1)) begin
               st_n   = LOCKED;
               fail_n = '0;
            end else begin
               tmr_n = tmr + 1'b1;
            end
`else
            st_n = LOCKED;
`endif
         end
      endcase
      sr_en = accept ? 4'd10 : 4'd0;
      sr_in = accept ? key : 5'd16;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= SETUP;
         cnt      <= 4'd0;
         tmr      <= '0;
         clr      <= 1'b1;
         code     <= '0;
         unlocked <= 1'b0;
      end else begin
         st       <= st_n;
         cnt      <= cnt_n;
         tmr      <= tmr_n;
         clr      <= clr_n;
         unlocked <= (st_n == OPEN);
         if (code_ld)
            code <= sr_out & MASK;
      end
   end

`ifdef LOCK_ALARM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fail  <= '0;
         alarm <= 1'b0;
      end else begin
         fail  <= fail_n;
         alarm <= (st_n == ALARM);
      end
   end
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with a behavioural external shift register.
module tb_lock_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  key = 5'd16;
   logic        key_strobe = 1'b0;
   logic [3:0]  sr_en;
   logic [4:0]  sr_in;
   logic        sr_rst;
   logic [31:0] sr_out = 32'd0;
   logic        unlocked, alarm;
   logic [1:0]  state;
   logic [3:0]  digit_cnt;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  pe_en;
   logic [4:0]  pe_in;

   lock_ctrl #(.CODE_LEN(4), .TRIES(3), .OPEN_CYC(8), .ALARM_CYC(6)) dut (
      .clk(clk), .rst(rst), .key(key), .key_strobe(key_strobe),
      .sr_en(sr_en), .sr_in(sr_in), .sr_rst(sr_rst), .sr_out(sr_out),
      .unlocked(unlocked), .alarm(alarm), .state(state), .digit_cnt(digit_cnt)
   );

   always #5 clk = ~clk;

   // external shift register the controller drives
   always @(posedge clk) begin
      if (sr_rst)            sr_out <= 32'd0;
      else if (sr_en == 4'd10) sr_out <= {sr_out[27:0], sr_in[3:0]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [4:0] k);
      key = k;
      key_strobe = 1'b1;
      #1;
      pe_en = sr_en;
      pe_in = sr_in;
      tick();
      key_strobe = 1'b0;
      key = 5'd16;
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int i = 3; i >= 0; i--) press({1'b0, c[4*i +: 4]});
      press(5'd10);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
`ifdef LOCK_ALARM_EN
      logic [1:0] st3_exp = 2'd3;
      logic       al3_exp = 1'b1;
      int         acnt_exp = 6;
`else
      logic [1:0] st3_exp = 2'd1;
      logic       al3_exp = 1'b0;
      int         acnt_exp = 0;
`endif
      // reset, with a digit strobe that must be blocked
      #1;
      key = 5'd3; key_strobe = 1'b1;
      tick(); tick();
      chk("rst_state", state, 2'd0);
      chk("rst_unlocked", unlocked, 1'b0);
      chk("rst_alarm", alarm, 1'b0);
      chk("rst_digit_cnt", digit_cnt, 4'd0);
      chk("rst_sr_en", sr_en, 4'd0);
      chk("rst_sr_in", sr_in, 5'd16);
      chk("rst_sr_rst", sr_rst, 1'b1);
      key_strobe = 1'b0; key = 5'd16;
      rst = 1'b0;
      chk("post_rst_sr_rst", sr_rst, 1'b1);
      tick();
      chk("post_rst_sr_rst_low", sr_rst, 1'b0);

      // program 1234
      press(5'd1);
      chk("prog_sr_en", pe_en, 4'd10);
      chk("prog_sr_in", pe_in, 5'd1);
      chk("prog_cnt1", digit_cnt, 4'd1);
      press(5'd2); press(5'd3); press(5'd4);
      chk("prog_cnt4", digit_cnt, 4'd4);
      chk("prog_sr_out", sr_out, 32'h1234);
      press(5'd10);
      chk("prog_locked", state, 2'd1);
      chk("prog_sr_rst", sr_rst, 1'b1);
      chk("prog_cnt0", digit_cnt, 4'd0);
      tick();
      chk("prog_sr_rst_one", sr_rst, 1'b0);
      chk("prog_sr_cleared", sr_out, 32'd0);

      // correct code opens for exactly 8 cycles
      enter_code(16'h1234);
      chk("open_state", state, 2'd2);
      chk("open_unlocked", unlocked, 1'b1);
      cnt = 0;
      while (unlocked === 1'b1 && cnt < 20) begin cnt++; tick(); end
      chk("open_cycles", cnt, 8);
      chk("open_relock", state, 2'd1);

      // ignored key codes
      press(5'd12);
      chk("key12_sr_en", pe_en, 4'd0);
      press(5'd16);
      chk("key16_cnt", digit_cnt, 4'd0);

      // wrong codes
      press(5'd1); press(5'd2); press(5'd3); press(5'd10);
      chk("short_state", state, 2'd1);
      chk("short_unlocked", unlocked, 1'b0);
      tick();
      enter_code(16'h5678);
      chk("wrong2_state", state, 2'd1);
      tick();
      enter_code(16'h1235);
      chk("wrong3_state", state, st3_exp);
      chk("wrong3_alarm", alarm, al3_exp);
      cnt = 0;
      while (alarm === 1'b1 && cnt < 20) begin
         key = (cnt % 2 == 1) ? 5'd10 : 5'd1;
         key_strobe = 1'b1;
         #1;
         chk("alarm_sr_en", sr_en, 4'd0);
         cnt++;
         tick();
         key_strobe = 1'b0; key = 5'd16;
      end
      chk("alarm_cycles", cnt, acnt_exp);
      chk("alarm_exit_state", state, 2'd1);
      chk("alarm_cnt", digit_cnt, 4'd0);
      tick();
      enter_code(16'h1111); tick();
      enter_code(16'h2222);
      chk("fail_cleared", state, 2'd1);
      tick();

      // digit saturation, then ENTER opens; ENTER in OPEN relocks
      press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
      chk("sat_sr_en", pe_en, 4'd0);
      chk("sat_cnt", digit_cnt, 4'd4);
      press(5'd10);
      chk("sat_open", state, 2'd2);
      tick();
      press(5'd10);
      chk("enter_relock", state, 2'd1);
      chk("enter_relock_unl", unlocked, 1'b0);
      tick();

      // digit during the flush cycle after CLEAR
      press(5'd7);
      press(5'd11);
      chk("clr_sr_rst", sr_rst, 1'b1);
      chk("clr_cnt", digit_cnt, 4'd0);
      press(5'd5);
      chk("flush_sr_en", pe_en, 4'd0);
      chk("flush_cnt", digit_cnt, 4'd0);
      chk("flush_sr_rst_low", sr_rst, 1'b0);
      chk("flush_state", state, 2'd1);

      // reprogram from OPEN via CLEAR
      enter_code(16'h1234);
      chk("reprog_open", state, 2'd2);
      tick();
      press(5'd11);
      chk("reprog_setup", state, 2'd0);
      chk("reprog_unl", unlocked, 1'b0);
      tick();
      enter_code(16'h9999);
      chk("reprog_locked", state, 2'd1);
      tick();
      enter_code(16'h1234);
      chk("old_rejected", state, 2'd1);
      chk("old_rejected_unl", unlocked, 1'b0);
      tick();
      enter_code(16'h9999);
      chk("new_accepted", state, 2'd2);
      chk("new_accepted_unl", unlocked, 1'b1);

      // reset aborts OPEN; short ENTER in SETUP stays in SETUP
      rst = 1'b1;
      tick();
      chk("abort_state", state, 2'd0);
      chk("abort_unl", unlocked, 1'b0);
      rst = 1'b0;
      tick();
      press(5'd1);
      press(5'd10);
      chk("setup_short", state, 2'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
